// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and types for the hazard scoreboard unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] PCSRC_SEQ   = 2'b00;

  // Pipeline-register enables produced by the priority logic.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
    logic redirect;
  } hazard_ctrl_t;

  function automatic fwd_sel_t fwd_select(
    input logic [7:0] rs,
    input logic [7:0] rd_m,
    input logic       we_m,
    input logic [7:0] rd_w,
    input logic       we_w
  );
    if (rs == 8'd0) return FWD_NONE;
    if (we_m && rs == rd_m) return FWD_M;
    if (we_w && rs == rd_w) return FWD_W;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/sb_lat_counter.sv
// rtl/sb_lat_counter.sv - one scoreboard countdown entry; busy while nonzero
module sb_lat_counter
  import hazard_pkg::*;
#(
  parameter int LAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             busy
);

  logic [LAT_W-1:0] count;

  // A load in the same cycle as a decrement wins, so a back-to-back reissue has no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - LAT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - forwarding, stall/flush priority, long-op scoreboard and perf counters
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter  int REG_AW   = 5,
  parameter  int MAX_LAT  = 16,
  parameter  int CNT_W    = 32,
  localparam int NUM_REGS = 2 ** REG_AW,
  localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   Rs1D,
  input  logic [REG_AW-1:0]   Rs2D,
  input  logic [REG_AW-1:0]   RdD,
  input  logic [REG_AW-1:0]   Rs1E,
  input  logic [REG_AW-1:0]   Rs2E,
  input  logic [REG_AW-1:0]   RdE,
  input  logic [REG_AW-1:0]   RdM,
  input  logic [REG_AW-1:0]   RdW,
  input  logic                RegWriteM,
  input  logic                RegWriteW,
  input  logic [1:0]          ResultSrcE,
  input  logic [1:0]          PCSrcE,
  input  logic                branch_mispredict_i,
  input  logic                CacheStall,
  input  logic                LongOpE,
  input  logic [LAT_W-1:0]    LongOpLatE,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                StallFetch,
  output logic                StallDecode,
  output logic                StallExecute,
  output logic                StallMemory,
  output logic                FlushDecode,
  output logic                FlushExecute,
  output logic                FlushWriteback,
  output logic                pc_redirect_o,
  output logic [NUM_REGS-1:0] sb_busy_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    redirect_cnt_o
);

  localparam logic [LAT_W-1:0] LAT_CAP = LAT_W'(MAX_LAT);

  hazard_ctrl_t     ctrl;
  logic             issue;
  logic [LAT_W-1:0] issue_val;
  logic             redirect_req;
  logic             load_use;
  logic             sb_hazard;
  logic [NUM_REGS-1:0] busy;

  // Issue is gated only by the cache stall; a redirect does not cancel an op already in E.
  assign issue     = LongOpE && !CacheStall && (RdE != '0) && (LongOpLatE != '0);
  assign issue_val = (LongOpLatE > LAT_CAP) ? LAT_CAP : LongOpLatE;

  assign busy[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    sb_lat_counter #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load    (issue && (RdE == REG_AW'(r))),
      .load_val(issue_val),
      .busy    (busy[r])
    );
  end

  assign sb_busy_o    = busy;
  assign redirect_req = branch_mispredict_i || (PCSrcE != PCSRC_SEQ);
  assign load_use     = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
  assign sb_hazard    = busy[Rs1D] || busy[Rs2D] || busy[RdD];

  always_comb begin
    ctrl      = '0;
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    if (!rst) begin
      ForwardAE = fwd_select(8'(Rs1E), 8'(RdM), RegWriteM, 8'(RdW), RegWriteW);
      ForwardBE = fwd_select(8'(Rs2E), 8'(RdM), RegWriteM, 8'(RdW), RegWriteW);
      if (CacheStall) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.stall_m = 1'b1;
        ctrl.flush_w = 1'b1;
      end else if (redirect_req) begin
        ctrl.redirect = 1'b1;
        ctrl.flush_d  = 1'b1;
        ctrl.flush_e  = 1'b1;
      end else if (load_use || sb_hazard) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
    end
  end

  assign StallFetch     = ctrl.stall_f;
  assign StallDecode    = ctrl.stall_d;
  assign StallExecute   = ctrl.stall_e;
  assign StallMemory    = ctrl.stall_m;
  assign FlushDecode    = ctrl.flush_d;
  assign FlushExecute   = ctrl.flush_e;
  assign FlushWriteback = ctrl.flush_w;
  assign pc_redirect_o  = ctrl.redirect;

  // Perf counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o    <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (ctrl.stall_f && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (ctrl.redirect && (redirect_cnt_o != '1)) begin
        redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
